// File: rtl/bitty_pkg.sv
// ============================================================================
// bitty_pkg
// Shared state encoding and default constants for the bitty program sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bitty_pkg;

  localparam int STATE_W = 3;
  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_ISSUE   = 3'd3,
    S_EXEC    = 3'd4,
    S_ADVANCE = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bitty_sequencer_if.sv
// ============================================================================
// bitty_sequencer_if
// Instruction-memory read port and core issue/done handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bitty_sequencer_if #(
  parameter int ADDR_W = 8
);

  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic              core_run;
  logic [15:0]       core_instr;
  logic              core_done;

  modport master (
    output imem_en, imem_addr, core_run, core_instr,
    input  imem_data, core_done
  );

  modport slave (
    input  imem_en, imem_addr, core_run, core_instr,
    output imem_data, core_done
  );

endinterface

`default_nettype wire

// File: rtl/bitty_seq_timeout.sv
// ============================================================================
// bitty_seq_timeout
// Clear/enable cycle counter that flags terminal count TIMEOUT-1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bitty_seq_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != C_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign terminal = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/bitty_sequencer.sv
// ============================================================================
// bitty_sequencer
// Fetches instructions, issues each to the core and advances the PC until
// last address, HALT word, stop request or core timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bitty_sequencer
  import bitty_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          TIMEOUT   = 16,
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [ADDR_W-1:0]    last_addr,
  bitty_sequencer_if.master    bus,
  output logic                 busy,
  output logic                 halted,
  output logic                 error,
  output logic [ADDR_W-1:0]    pc,
  output logic [15:0]          instr_count
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  logic [15:0]       r_count;
  logic              r_stop_req;

  logic w_launch;
  logic w_latch;
  logic w_retire;
  logic w_step;
  logic w_imem_en;
  logic w_core_run;
  logic w_tmo_clear;
  logic w_tmo_en;
  logic w_tmo_term;

  bitty_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_tmo_clear),
    .enable   (w_tmo_en),
    .terminal (w_tmo_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_launch    = 1'b0;
    w_latch     = 1'b0;
    w_retire    = 1'b0;
    w_step      = 1'b0;
    w_imem_en   = 1'b0;
    w_core_run  = 1'b0;
    w_tmo_clear = 1'b0;
    w_tmo_en    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start && !stop) begin
          w_launch = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_FETCH: begin
        w_imem_en = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        // A HALT word ends the program without ever reaching the core.
        if (bus.imem_data == HALT_WORD) begin
          w_next = S_DONE;
        end else begin
          w_latch = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_core_run  = 1'b1;
        w_tmo_clear = 1'b1;
        w_next      = S_EXEC;
      end
      S_EXEC: begin
        if (bus.core_done) begin
          w_next = S_ADVANCE;
        end else if (w_tmo_term) begin
          w_next = S_ERROR;
        end else begin
          w_tmo_en = 1'b1;
        end
      end
      S_ADVANCE: begin
        w_retire = 1'b1;
        if (r_stop_req || (r_pc == last_addr)) begin
          w_next = S_DONE;
        end else begin
          w_step = 1'b1;
          w_next = S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_count    <= '0;
      r_stop_req <= 1'b0;
    end else begin
      if (w_launch) begin
        r_pc       <= '0;
        r_count    <= '0;
        r_stop_req <= 1'b0;
      end else begin
        if (busy && stop) begin
          r_stop_req <= 1'b1;
        end
        if (w_retire && (r_count != 16'hFFFF)) begin
          r_count <= r_count + 16'd1;
        end
        if (w_step) begin
          r_pc <= r_pc + 1'b1;
        end
      end
      if (w_latch) begin
        r_instr <= bus.imem_data;
      end
    end
  end

  assign busy           = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_ISSUE) ||
                          (r_state == S_EXEC)  || (r_state == S_ADVANCE);
  assign halted         = (r_state == S_DONE);
  assign error          = (r_state == S_ERROR);
  assign pc             = r_pc;
  assign instr_count    = r_count;
  assign bus.imem_en    = w_imem_en;
  assign bus.imem_addr  = r_pc;
  assign bus.core_run   = w_core_run;
  assign bus.core_instr = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_bitty_sequencer.sv
// ============================================================================
// tb_bitty_sequencer
// Self-checking bench: per-program cycle timeline model plus directed cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bitty_sequencer;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int TL      = 512;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic              busy, halted, error;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instr_count;

  bitty_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  bitty_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .HALT_WORD(16'hFFFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .last_addr   (last_addr),
    .bus         (bus),
    .busy        (busy),
    .halted      (halted),
    .error       (error),
    .pc          (pc),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) if (bus.imem_en) bus.imem_data <= mem[bus.imem_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program description and the expected per-cycle timeline derived from it.
  int  delay [64];
  int  stop_k, stop_ofs;
  bit  exp_busy [TL], exp_halt [TL], exp_err [TL], exp_en [TL], exp_run [TL];
  bit  drv_done [TL], drv_stop [TL], exec_cyc [TL];
  logic [15:0] exp_instr [TL];
  logic [7:0]  exp_addr [TL];
  int  tl_len, exp_pc_f, exp_cnt_f;
  bit  exp_err_f;
  int  cur_o = 0;
  bit  chk_on = 1'b0;

  task automatic build_model();
    int c, k, pc_m, cnt, t, d, term;
    bit is_err;
    for (int i = 0; i < TL; i++) begin
      exp_busy[i] = 0; exp_halt[i] = 0; exp_err[i] = 0; exp_en[i] = 0; exp_run[i] = 0;
      drv_done[i] = 0; drv_stop[i] = 0; exec_cyc[i] = 0; exp_instr[i] = '0; exp_addr[i] = '0;
    end
    c = 1; k = 0; pc_m = 0; cnt = 0; term = 0; is_err = 0;
    forever begin
      exp_busy[c] = 1; exp_en[c] = 1; exp_addr[c] = 8'(pc_m);
      exp_busy[c+1] = 1;
      if (mem[pc_m] == 16'hFFFF) begin term = c + 2; break; end
      t = c + 2;
      exp_busy[t] = 1; exp_run[t] = 1; exp_instr[t] = mem[pc_m];
      d = delay[k];
      if (d > TIMEOUT) begin
        for (int j = 1; j <= TIMEOUT; j++) begin exp_busy[t+j] = 1; exec_cyc[t+j] = 1; end
        term = t + TIMEOUT + 1; is_err = 1;
        break;
      end
      for (int j = 1; j <= d; j++) begin exp_busy[t+j] = 1; exec_cyc[t+j] = 1; end
      drv_done[t+d] = 1;
      if (k == stop_k) drv_stop[t + 1 + (stop_ofs % d)] = 1;
      exp_busy[t+d+1] = 1;
      cnt = (cnt == 65535) ? cnt : cnt + 1;
      if (k == stop_k || pc_m == int'(last_addr)) begin term = t + d + 2; break; end
      pc_m++; k++; c = t + d + 2;
    end
    for (int j = term; j < term + 3; j++) begin exp_halt[j] = !is_err; exp_err[j] = is_err; end
    tl_len = term + 3; exp_pc_f = pc_m; exp_cnt_f = cnt; exp_err_f = is_err;
  endtask

  always @(negedge clk) begin
    if (chk_on && cur_o >= 1 && cur_o < tl_len) begin
      chk("busy", 32'(busy), 32'(exp_busy[cur_o]));
      chk("halted", 32'(halted), 32'(exp_halt[cur_o]));
      chk("error", 32'(error), 32'(exp_err[cur_o]));
      chk("imem_en", 32'(bus.imem_en), 32'(exp_en[cur_o]));
      chk("core_run", 32'(bus.core_run), 32'(exp_run[cur_o]));
      if (exp_en[cur_o]) chk("imem_addr", 32'(bus.imem_addr), 32'(exp_addr[cur_o]));
      if (exp_run[cur_o]) chk("core_instr", 32'(bus.core_instr), 32'(exp_instr[cur_o]));
    end
  end

  task automatic run_program(input bit noise);
    build_model();
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b0; bus.core_done = 1'b0; cur_o = 0; chk_on = 1'b1;
    for (int o = 1; o < tl_len; o++) begin
      @(posedge clk); #1;
      cur_o = o;
      start = noise && exp_busy[o] && ($urandom % 8 == 0);
      stop  = drv_stop[o] || (noise && (exp_halt[o] || exp_err[o]) && ($urandom % 2 == 0));
      bus.core_done = drv_done[o] || (noise && !exec_cyc[o] && ($urandom % 4 == 0));
    end
    @(posedge clk); #1;
    chk_on = 1'b0; start = 1'b0; stop = 1'b0; bus.core_done = 1'b0;
    @(negedge clk);
    chk("final_pc", 32'(pc), 32'(exp_pc_f));
    chk("final_count", 32'(instr_count), 32'(exp_cnt_f));
    chk("final_halted", 32'(halted), 32'(!exp_err_f));
    chk("final_error", 32'(error), 32'(exp_err_f));
    chk("final_busy", 32'(busy), 32'd0);
  endtask

  task automatic set_program(input int la, input int d, input int sk);
    last_addr = 8'(la);
    for (int i = 0; i < 64; i++) delay[i] = d;
    stop_k = sk; stop_ofs = 0;
  endtask

  initial begin
    int seen;
    bit run_prev;
    bus.core_done = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101 + 16'h1000);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0); chk("rst_halted", 32'(halted), 0);
    chk("rst_error", 32'(error), 0); chk("rst_pc", 32'(pc), 0);
    chk("rst_count", 32'(instr_count), 0); chk("rst_run", 32'(bus.core_run), 0);
    chk("rst_instr", 32'(bus.core_instr), 0); chk("rst_en", 32'(bus.imem_en), 0);
    @(posedge clk); #1 reset = 1'b1;

    // start together with stop in IDLE is ignored
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("startstop_busy", 32'(busy), 0); chk("startstop_en", 32'(bus.imem_en), 0);
    chk("startstop_halted", 32'(halted), 0);

    // 4-word program, done one cycle after run
    mem[0] = 16'hA001; mem[1] = 16'hB002; mem[2] = 16'hC003; mem[3] = 16'hD004;
    set_program(3, 1, -1);
    run_program(1'b0);
    chk("t1_pc", 32'(pc), 32'd3); chk("t1_count", 32'(instr_count), 32'd4);
    chk("t1_halted", 32'(halted), 32'd1);

    // HALT word at address 2
    mem[2] = 16'hFFFF;
    set_program(7, 2, -1);
    run_program(1'b0);
    chk("t2_pc", 32'(pc), 32'd2); chk("t2_count", 32'(instr_count), 32'd2);
    chk("t2_halted", 32'(halted), 32'd1);
    mem[2] = 16'hC003;

    // core never done on first instruction
    set_program(3, 1, -1); delay[0] = 1000;
    run_program(1'b0);
    chk("t3_error", 32'(error), 32'd1); chk("t3_busy", 32'(busy), 32'd0);

    // stop during EXEC of instruction 1, restarting from ERROR
    set_program(3, 3, 1); stop_ofs = 1;
    run_program(1'b0);
    chk("t4_pc", 32'(pc), 32'd1); chk("t4_count", 32'(instr_count), 32'd2);
    chk("t4_halted", 32'(halted), 32'd1);

    // done landing in the final EXEC cycle still completes
    set_program(1, TIMEOUT, -1);
    run_program(1'b1);

    // randomized programs with spurious start/stop/done noise
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 16; i++) mem[i] = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
      last_addr = 8'($urandom % 16);
      for (int i = 0; i < 64; i++)
        delay[i] = ($urandom % 12 == 0) ? TIMEOUT + int'($urandom % 3) : int'($urandom_range(1, 6));
      stop_k = ($urandom % 4 == 0) ? int'($urandom % 16) : -1;
      stop_ofs = int'($urandom % 8);
      run_program(1'b1);
    end

    // asynchronous reset during EXEC of the second instruction
    mem[0] = 16'hA001; mem[1] = 16'hB002; mem[2] = 16'hC003; last_addr = 8'd2;
    @(posedge clk); #1 start = 1'b1;
    seen = 0; run_prev = 1'b0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      bus.core_done = run_prev;
      @(negedge clk);
      run_prev = bus.core_run;
      if (bus.core_run) seen++;
    end
    chk("t6_runs_seen", 32'(seen), 32'd2);
    @(posedge clk); #1 bus.core_done = 1'b0;
    @(negedge clk);
    chk("t6_busy_pre", 32'(busy), 32'd1); chk("t6_pc_pre", 32'(pc), 32'd1);
    chk("t6_count_pre", 32'(instr_count), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0); chk("t6_pc", 32'(pc), 0);
    chk("t6_count", 32'(instr_count), 0); chk("t6_instr", 32'(bus.core_instr), 0);
    chk("t6_addr", 32'(bus.imem_addr), 0); chk("t6_halted", 32'(halted), 0);
    chk("t6_error", 32'(error), 0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 bus.core_done = i[0];
      @(negedge clk);
      chk("t6_idle_busy", 32'(busy), 0); chk("t6_idle_run", 32'(bus.core_run), 0);
      chk("t6_idle_pc", 32'(pc), 0);
    end
    bus.core_done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
